reg_file_mp: RTL
================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-read-port register file for the FASA datapath, successor to the single-write RegFile.
//  - NR combinational read ports, one arbitrated write per cycle, dedicated immediate register.
//  - Register-to-register copy, generalising the CPP/CYY moves.
//  - Sequenced bulk clear (one register per cycle, Busy/ClearDone handshake).
//  - Sits between decode (addresses/controls) and ALU/data-memory (operands, load data).
// PARAMETERS
//  W       8  data width (bits)
//  A       4  address width; depth = 2**A
//  NR      2  number of read ports (1..4)
//  IMM_REG 3  register index written by immediate load
//  ZERO_R0 0  1: r0 reads as zero and ignores all writes (MIPS style); 0: r0 general purpose
// PORTS
//  Clk        in   1     clock, all state on rising edge
//  ResetN     in   1     asynchronous, active-low reset
//  WriteEn    in   1     write WrData to WrAddr
//  WrAddr     in   A     write address
//  WrData     in   W     write data (ALU result / load data)
//  ImmEn      in   1     write Immediate to IMM_REG
//  Immediate  in   W     immediate value
//  CopyEn     in   1     Reg[CopyDst] <= Reg[CopySrc]
//  CopySrc    in   A     copy source
//  CopyDst    in   A     copy destination
//  RdAddr     in   NR*A  packed read addresses; port i = RdAddr[i*A +: A]
//  RdData     out  NR*W  packed read data;     port i = RdData[i*W +: W]
//  ClearReq   in   1     start bulk clear (sampled in IDLE only)
//  Busy       out  1     high while state CLEAR
//  ClearDone  out  1     one-cycle pulse after the last register is cleared
// BEHAVIOUR
//  - Reset (ResetN=0, async): all registers 0, state IDLE, clear counter 0, Busy=0, ClearDone=0.
//  - Reads: combinational, RdData[i] = Reg[RdAddr[i]]; ZERO_R0=1 forces 0 for address 0.
//  - Write arbitration, one grant per cycle: ImmEn > CopyEn > WriteEn; losing requests are dropped, not queued.
//  - Copy reads the pre-edge source value; CopySrc==CopyDst is a no-op.
//  - Writes to r0 are discarded when ZERO_R0=1.
//  - FSM IDLE -> CLEAR on ClearReq; CLEAR writes 0 to Reg[cnt], cnt++ each cycle.
//  - CLEAR -> DONE when cnt==2**A-1 has been written; cnt wraps to 0.
//  - DONE lasts one cycle with ClearDone=1, then -> IDLE.
//  - Full clear: ClearReq at edge k; Busy at k+1..k+2**A; ClearDone at k+2**A+1.
//  - During CLEAR and DONE, ImmEn/CopyEn/WriteEn are ignored and ClearReq is ignored.
//  - Reads stay live during CLEAR and return the current partially-cleared contents.
//  - ResetN asserted mid-clear: immediate return to IDLE, all registers 0, no ClearDone pulse.
// CONFIGURATION
//  - Macro REGFILE_BYPASS_EN defined: a read whose address matches this cycle's granted write destination returns the value being written.
//    - Covers imm, copy and write grants; clear writes are never bypassed; ZERO_R0 still forces 0.
//  - Macro undefined: reads return the pre-edge value; the new value is visible the cycle after the edge.
// STRUCTURE
//  - Package Definitions gets:
//    - typedef enum {RF_IDLE, RF_CLEAR, RF_DONE} rf_state_t
//    - typedef enum {GNT_NONE, GNT_IMM, GNT_COPY, GNT_WR} rf_grant_t
//  - One sub-module, reg_clear_seq: the FSM plus the A-bit counter.
//    - Outputs clr_we, clr_addr, Busy, ClearDone.
//  - Storage, arbitration and read muxes stay in reg_file_mp.
// TESTING
//  1. Reset with ResetN=0 while loaded -> all RdData=0, Busy=0 immediately, before any Clk edge.
//  2. WriteEn=1, ImmEn=1, WrAddr=3, WrData=8'hAA, Immediate=8'h55 in one cycle -> Reg3=8'h55 (imm wins).
//  3. Reg5=8'h3C, CopyEn with CopySrc=5, CopyDst=1 -> Reg1=8'h3C next cycle; Reg5 unchanged.
//  4. Write 8'hF0 to r7 with RdAddr port0=7, same cycle:
//     - BYPASS_EN -> 8'hF0
//     - else -> old value, then 8'hF0 next cycle
//  5. ClearReq with all regs 8'hFF, A=4:
//     - Busy for 16 cycles, ClearDone one cycle later
//     - WriteEn during Busy is ignored; all regs 0
//  6. ResetN pulsed low at clear cycle 6 -> IDLE, all 0, no ClearDone.
//     ZERO_R0=1: write 8'h11 to r0 -> reads 0.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// Shared types for the multi-port register file and its clear sequencer.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
package reg_file_mp_pkg;

  typedef enum logic [1:0] {
    RF_IDLE  = 2'd0,
    RF_CLEAR = 2'd1,
    RF_DONE  = 2'd2
  } rf_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IMM  = 2'd1,
    GNT_COPY = 2'd2,
    GNT_WR   = 2'd3
  } rf_grant_t;

  localparam int unsigned MAX_READ_PORTS = 4;

endpackage

// File: rtl/reg_file_mp_clear_seq.sv
// Bulk-clear sequencer: walks every register index once, one per cycle,
// then pulses clear_done for a single cycle before returning to idle.
module reg_clear_seq
  import reg_file_mp_pkg::*;
#(
  parameter int A = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_req,
  output logic         clr_we,
  output logic [A-1:0] clr_addr,
  output logic         busy,
  output logic         clear_done
);

  rf_state_t    state_q;
  logic [A-1:0] cnt_q;
  logic         busy_q;
  logic         done_q;

  // Clear FSM with registered busy/done flags; counter wraps to 0 after the top index.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RF_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        RF_IDLE: begin
          if (clear_req) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RF_CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_q <= RF_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        RF_DONE: begin
          state_q <= RF_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= RF_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we     = busy_q;
  assign clr_addr   = cnt_q;
  assign busy       = busy_q;
  assign clear_done = done_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file: NR combinational reads, one arbitrated
// write per cycle (immediate > copy > write), plus sequenced bulk clear.
// Optional feature macro: REGFILE_BYPASS_EN forwards the granted write to
// matching read ports in the same cycle.
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter int W       = 8,
  parameter int A       = 4,
  parameter int NR      = 2,
  parameter int IMM_REG = 3,
  parameter int ZERO_R0 = 0
) (
  input  logic            Clk,
  input  logic            ResetN,
  input  logic            WriteEn,
  input  logic [A-1:0]    WrAddr,
  input  logic [W-1:0]    WrData,
  input  logic            ImmEn,
  input  logic [W-1:0]    Immediate,
  input  logic            CopyEn,
  input  logic [A-1:0]    CopySrc,
  input  logic [A-1:0]    CopyDst,
  input  logic [NR*A-1:0] RdAddr,
  output logic [NR*W-1:0] RdData,
  input  logic            ClearReq,
  output logic            Busy,
  output logic            ClearDone
);

  localparam int          DEPTH    = 2 ** A;
  localparam logic [A-1:0] IMM_ADDR = A'(IMM_REG);

  logic [W-1:0] regs_q [DEPTH];
  logic [W-1:0] regs_d [DEPTH];

  logic         clr_we;
  logic [A-1:0] clr_addr;
  logic         seq_busy;
  logic         seq_done;

  rf_grant_t    grant;
  logic         wr_en;
  logic [A-1:0] wr_dst;
  logic [W-1:0] wr_val;
  logic [W-1:0] copy_val;

  reg_clear_seq #(.A(A)) u_clear_seq (
    .clk        (Clk),
    .rst_n      (ResetN),
    .clear_req  (ClearReq),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr),
    .busy       (seq_busy),
    .clear_done (seq_done)
  );

  assign Busy      = seq_busy;
  assign ClearDone = seq_done;

  // Copy source as architecturally visible before the edge (r0 reads 0 when hardwired).
  assign copy_val = (ZERO_R0 != 0 && CopySrc == '0) ? '0 : regs_q[CopySrc];

  // Single-grant arbitration; all requests are dropped while clearing or signalling done.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant  = GNT_NONE;
    wr_dst = '0;
    wr_val = '0;
    wr_en  = 1'b0;
    if (!seq_busy && !seq_done) begin
      if (ImmEn) begin
        grant  = GNT_IMM;
        wr_dst = IMM_ADDR;
        wr_val = Immediate;
      end else if (CopyEn) begin
        grant  = GNT_COPY;
        wr_dst = CopyDst;
        wr_val = copy_val;
      end else if (WriteEn) begin
        grant  = GNT_WR;
        wr_dst = WrAddr;
        wr_val = WrData;
      end
    end
    // A copy onto itself still wins arbitration but changes nothing.
    wr_en = (grant != GNT_NONE)
         && !(grant == GNT_COPY && CopySrc == CopyDst)
         && !(ZERO_R0 != 0 && wr_dst == '0);
  end

  // Next-state of the storage array: clear writes win, otherwise the granted write.
  // NOTE: blocking assignments here build the next value combinationally, in order.
  always_comb begin
    regs_d = regs_q;
    if (clr_we) begin
      regs_d[clr_addr] = '0;
    end else if (wr_en) begin
      regs_d[wr_dst] = wr_val;
    end
  end

  // Storage flops.
  // NOTE: the whole array is reset because asynchronous reset must zero every register.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port muxes with optional same-cycle forwarding of the granted write.
  always_comb begin
    RdData = '0;
    for (int p = 0; p < NR; p++) begin
      logic [A-1:0] ra;
      logic [W-1:0] rv;
      ra = RdAddr[p*A +: A];
      rv = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && ra == wr_dst) rv = wr_val;
`endif
      if (ZERO_R0 != 0 && ra == '0) rv = '0;
      RdData[p*W +: W] = rv;
    end
  end

endmodule
